// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch control interface: raw button/switch inputs toward the controller
// and the registered control levels/pulses toward the counter and display.
//   btn_start, btn_lap, speed_sw : raw, asynchronous, bouncy inputs
//   run      : counter enable level
//   clear    : one-cycle pulse that zeroes the counter digits
//   freeze   : display-hold level (lap view)
//   speed_up : synchronized, debounced copy of speed_sw
interface stopwatch_ctrl_if;
  logic btn_start;
  logic btn_lap;
  logic speed_sw;
  logic run;
  logic clear;
  logic freeze;
  logic speed_up;

  modport slave (
    input  btn_start, btn_lap, speed_sw,
    output run, clear, freeze, speed_up
  );

  modport master (
    output btn_start, btn_lap, speed_sw,
    input  run, clear, freeze, speed_up
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: synchronizes and debounces two push-buttons and a
// slide switch, turns button presses into one-cycle events and runs the
// IDLE/RUNNING/LAP/PAUSED state machine that drives run/freeze/clear.
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   sw    : stopwatch_ctrl_if.slave (raw inputs in, control outputs out)
// Latency: raw button rise -> output change is DEBOUNCE_CYCLES+4 edges;
// speed_sw change -> speed_up is DEBOUNCE_CYCLES+2 edges.

// One input channel: 2-flop synchronizer followed by a stable-level debouncer.
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          stable;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= '0;
      cnt    <= '0;
      stable <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      // Any cycle that agrees with the stable level restarts the count, so
      // only an uninterrupted run of DEBOUNCE_CYCLES differing cycles flips it.
      if (sync[1] == stable) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        stable <= ~stable;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign level = stable;
endmodule

module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic             clk,
  input  logic             reset,
  stopwatch_ctrl_if.slave  sw
);
  localparam int NUM_IN = 3;  // 0: start, 1: lap, 2: speed

  typedef enum logic [1:0] {IDLE, RUNNING, LAP, PAUSED} state_t;

  logic [NUM_IN-1:0] raw;
  logic [NUM_IN-1:0] lvl;
  logic [1:0]        lvl_q;
  logic              start_evt, lap_evt;
  state_t            state_q, state_n;
  logic              clr_n;
  logic              run_q, freeze_q, clear_q;

  assign raw = {sw.speed_sw, sw.btn_lap, sw.btn_start};

  for (genvar g = 0; g < NUM_IN; g++) begin : g_db
    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .rst_n (reset),
      .raw   (raw[g]),
      .level (lvl[g])
    );
  end

  // Press events fire on the stable 0->1 only; holds and releases are silent.
  // lvl_q resets to 0, so a button held through reset reads as a new press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lvl_q     <= '0;
      start_evt <= 1'b0;
      lap_evt   <= 1'b0;
    end else begin
      lvl_q     <= lvl[1:0];
      start_evt <= lvl[0] & ~lvl_q[0];
      lap_evt   <= lvl[1] & ~lvl_q[1];
    end
  end

  // start_evt is tested first everywhere so a coincident lap_evt is dropped.
  always_comb begin
    state_n = state_q;
    clr_n   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_evt)    state_n = RUNNING;
        else if (lap_evt) clr_n   = 1'b1;
      end
      RUNNING: begin
        if (start_evt)    state_n = PAUSED;
        else if (lap_evt) state_n = LAP;
      end
      LAP: begin
        if (start_evt)    state_n = PAUSED;
        else if (lap_evt) state_n = RUNNING;
      end
      PAUSED: begin
        if (start_evt) begin
          state_n = RUNNING;
        end else if (lap_evt) begin
          state_n = IDLE;
          clr_n   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they change on the same
  // edge as the state itself.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      run_q    <= 1'b0;
      freeze_q <= 1'b0;
      clear_q  <= 1'b0;
    end else begin
      state_q  <= state_n;
      run_q    <= (state_n == RUNNING) || (state_n == LAP);
      freeze_q <= (state_n == LAP);
      clear_q  <= clr_n;
    end
  end

  assign sw.run      = run_q;
  assign sw.freeze   = freeze_q;
  assign sw.clear    = clear_q;
  assign sw.speed_up = lvl[2];  // debouncer stable level is already a flop
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl with DEBOUNCE_CYCLES=4. Stimulus pushes expected
// {run,freeze,clear,speed_up} values tagged with the absolute edge count at
// which they must hold; a negedge monitor pops and compares them.
module tb_stopwatch_ctrl;
  localparam int DB = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;

  stopwatch_ctrl_if sif ();

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk   (clk),
    .reset (reset),
    .sw    (sif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0] outs;
  assign outs = {sif.run, sif.freeze, sif.clear, sif.speed_up};

  typedef struct {
    int         at;
    string      tag;
    logic [3:0] v;
  } exp_t;
  exp_t q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expect {run,freeze,clear,speed_up} == v after d more rising edges.
  task automatic push(input int d, input string tag, input logic [3:0] v);
    exp_t e;
    e.at  = cyc + d;
    e.tag = tag;
    e.v   = v;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].at == cyc) begin
        chk(q[i].tag, {28'd0, outs}, {28'd0, q[i].v});
        q.delete(i);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: cycle %0d, want finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    sif.btn_start = 1'b0;
    sif.btn_lap   = 1'b0;
    sif.speed_sw  = 1'b0;
    tick(3);
    chk("reset_outs", {28'd0, outs}, 32'd0);
    reset = 1'b1;
    tick(2);

    // Start: clean 20-cycle press, run rises on edge DB+4.
    push(7, "A_pre", 4'b0000);
    push(8, "A_run", 4'b1000);
    push(20, "A_hold", 4'b1000);
    sif.btn_start = 1'b1; tick(20);
    sif.btn_start = 1'b0; tick(12);

    // Reset from RUNNING must drop run without waiting for a clock.
    reset = 1'b0; #1;
    chk("B_rst_async", {28'd0, outs}, 32'd0);
    tick(3);
    reset = 1'b1; tick(2);

    // Bounce: 2-cycle toggles never satisfy the 4-cycle stability window.
    push(10, "B_bounce10", 4'b0000);
    push(20, "B_bounce20", 4'b0000);
    push(30, "B_bounce30", 4'b0000);
    push(40, "B_bounce40", 4'b0000);
    for (int i = 0; i < 30; i++) begin
      if (i % 2 == 0) sif.btn_start = ~sif.btn_start;
      tick(1);
    end
    sif.btn_start = 1'b0; tick(10);
    // A clean press gives exactly one event: run stays up after release.
    push(7, "B_clean_pre", 4'b0000);
    push(8, "B_clean_run", 4'b1000);
    push(30, "B_one_evt", 4'b1000);
    sif.btn_start = 1'b1; tick(10);
    sif.btn_start = 1'b0; tick(20);

    // Lap cycle from RUNNING: lap, lap, start, lap.
    push(7, "C_lap1_pre", 4'b1000);
    push(8, "C_lap1", 4'b1100);
    sif.btn_lap = 1'b1; tick(8); sif.btn_lap = 1'b0; tick(8);
    push(7, "C_lap2_pre", 4'b1100);
    push(8, "C_lap2", 4'b1000);
    sif.btn_lap = 1'b1; tick(8); sif.btn_lap = 1'b0; tick(8);
    push(7, "C_pause_pre", 4'b1000);
    push(8, "C_pause", 4'b0000);
    sif.btn_start = 1'b1; tick(8); sif.btn_start = 1'b0; tick(8);
    push(7, "C_clr_pre", 4'b0000);
    push(8, "C_clr", 4'b0010);
    push(9, "C_clr_end", 4'b0000);
    push(16, "C_idle", 4'b0000);
    sif.btn_lap = 1'b1; tick(8); sif.btn_lap = 1'b0; tick(8);

    // Simultaneous press in RUNNING acts as start only.
    push(8, "D_run", 4'b1000);
    sif.btn_start = 1'b1; tick(8); sif.btn_start = 1'b0; tick(8);
    push(7, "D_both_pre", 4'b1000);
    push(8, "D_both", 4'b0000);
    push(9, "D_both_noclr", 4'b0000);
    push(16, "D_paused", 4'b0000);
    sif.btn_start = 1'b1; sif.btn_lap = 1'b1; tick(8);
    sif.btn_start = 1'b0; sif.btn_lap = 1'b0; tick(8);

    // Reach LAP, then reset while btn_start is mid-debounce and stays held.
    push(8, "E_run", 4'b1000);
    sif.btn_start = 1'b1; tick(8); sif.btn_start = 1'b0; tick(8);
    push(8, "E_lap", 4'b1100);
    sif.btn_lap = 1'b1; tick(8); sif.btn_lap = 1'b0; tick(8);
    sif.btn_start = 1'b1; tick(2);
    reset = 1'b0; #1;
    chk("E_rst_async", {28'd0, outs}, 32'd0);
    tick(3);
    // The held button enters the synchronizer on the first edge after
    // release; run follows 7 edges after that one.
    reset = 1'b1;
    push(7, "E_held_pre", 4'b0000);
    push(8, "E_held_run", 4'b1000);
    push(24, "E_held_once", 4'b1000);
    tick(12);
    sif.btn_start = 1'b0; tick(12);

    // Speed switch: a 3-cycle pulse is filtered, a long one passes.
    push(3, "F_glitch3", 4'b1000);
    push(6, "F_glitch6", 4'b1000);
    push(9, "F_glitch9", 4'b1000);
    sif.speed_sw = 1'b1; tick(3);
    sif.speed_sw = 1'b0; tick(6);
    push(5, "F_spd_pre", 4'b1000);
    push(6, "F_spd_up", 4'b1001);
    push(10, "F_spd_hold", 4'b1001);
    sif.speed_sw = 1'b1; tick(10);
    push(5, "F_spd_fall_pre", 4'b1001);
    push(6, "F_spd_fall", 4'b1000);
    sif.speed_sw = 1'b0; tick(10);

    tick(3);
    chk("queue_drained", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
